// File: rtl/axil_master_ctrl.sv
// axil_master_ctrl
// Single-outstanding AXI4-Lite master. Each command accepted on the cmd_* port
// becomes one AXI-Lite read or write. The slave's data and response are returned
// on the rsp_* port and held there until the response is consumed.
// Every output comes straight from a flop.
module axil_master_ctrl #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  // command port
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        busy,
  // AXI-Lite master
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,
  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready
);

  localparam int SW = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_e;

  // All registered outputs, grouped so that reset and hold-by-default stay in one place.
  typedef struct packed {
    logic                      cmd_ready;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic                      awvalid;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]             wstrb;
    logic                      wvalid;
    logic                      bready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic                      arvalid;
    logic                      rready;
    logic                      rsp_valid;
    logic                      rsp_write;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]                rsp_resp;
    logic                      busy;
  } out_t;

  state_e state_q, state_d;
  out_t   out_q, out_d;

  logic cmd_accept, aw_hs, w_hs, aw_done, w_done, b_hs, ar_hs, r_hs, rsp_hs;

  assign cmd_accept = (state_q == IDLE) && cmd_valid && out_q.cmd_ready;
  assign aw_hs      = out_q.awvalid && m_axil_awready;
  assign w_hs       = out_q.wvalid && m_axil_wready;
  // A write channel is done once its beat has been taken, now or on an earlier cycle.
  assign aw_done    = aw_hs || !out_q.awvalid;
  assign w_done     = w_hs || !out_q.wvalid;
  assign b_hs       = m_axil_bvalid && out_q.bready;
  assign ar_hs      = out_q.arvalid && m_axil_arready;
  assign r_hs       = m_axil_rvalid && out_q.rready;
  assign rsp_hs     = out_q.rsp_valid && rsp_ready;

  // State register and registered outputs. An asynchronous reset abandons any transfer in flight.
  // NOTE: use non-blocking (<=) in clocked blocks so all flops update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic: one transaction at a time, from acceptance to the consumed response.
  // NOTE: assign a default first in always_comb so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_accept) state_d = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done && w_done) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = RSP;
      RD_REQ:  if (ar_hs) state_d = RD_RESP;
      RD_RESP: if (r_hs) state_d = RSP;
      RSP:     if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next value of every registered output. Each output holds its value unless its own event occurs.
  always_comb begin
    out_d      = out_q;
    out_d.busy = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        out_d.cmd_ready = !cmd_accept;
        if (cmd_accept) begin
          if (cmd_write) begin
            out_d.awaddr  = cmd_addr;
            out_d.wdata   = cmd_wdata;
            out_d.wstrb   = cmd_wstrb;
            out_d.awvalid = 1'b1;
            out_d.wvalid  = 1'b1;
          end else begin
            out_d.araddr  = cmd_addr;
            out_d.arvalid = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) out_d.awvalid = 1'b0;
        if (w_hs)  out_d.wvalid  = 1'b0;
        if (aw_done && w_done) out_d.bready = 1'b1;
      end
      WR_RESP: begin
        if (b_hs) begin
          out_d.bready    = 1'b0;
          out_d.rsp_valid = 1'b1;
          out_d.rsp_write = 1'b1;
          out_d.rsp_rdata = '0;
          out_d.rsp_resp  = m_axil_bresp;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          out_d.arvalid = 1'b0;
          out_d.rready  = 1'b1;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          out_d.rready    = 1'b0;
          out_d.rsp_valid = 1'b1;
          out_d.rsp_write = 1'b0;
          out_d.rsp_rdata = m_axil_rdata;
          out_d.rsp_resp  = m_axil_rresp;
        end
      end
      RSP: begin
        if (rsp_hs) begin
          out_d.rsp_valid = 1'b0;
          out_d.cmd_ready = 1'b1;
        end
      end
      default: out_d = '0;
    endcase
  end

  assign cmd_ready      = out_q.cmd_ready;
  assign rsp_valid      = out_q.rsp_valid;
  assign rsp_write      = out_q.rsp_write;
  assign rsp_rdata      = out_q.rsp_rdata;
  assign rsp_resp       = out_q.rsp_resp;
  assign busy           = out_q.busy;
  assign m_axil_awaddr  = out_q.awaddr;
  assign m_axil_awvalid = out_q.awvalid;
  assign m_axil_wdata   = out_q.wdata;
  assign m_axil_wstrb   = out_q.wstrb;
  assign m_axil_wvalid  = out_q.wvalid;
  assign m_axil_bready  = out_q.bready;
  assign m_axil_araddr  = out_q.araddr;
  assign m_axil_arvalid = out_q.arvalid;
  assign m_axil_rready  = out_q.rready;

endmodule
